progmem_arbiter: RTL and testbench
==================================

// Module: progmem_arbiter
// PURPOSE
//   Round-robin arbiter sharing one synchronous-read program memory between
//   N_CORES CORE instances. Each core's progmem_addr becomes a fetch request.
//   One request is granted per cycle and forwarded to the memory port. The
//   fetched instruction returns one cycle later with a per-core valid strobe.
//   Sits between the CORE array and the single progmem in the multicore top.
// PARAMETERS
//   N_CORES  4             number of requesting cores (>=2)
//   ADDR_W   `INST_ADDR_W  instruction address width
//   DATA_W   `INST_W       instruction word width
// PORTS
//   clk        in   1               system clock, rising edge
//   rst        in   1               asynchronous, active-high reset
//   en         in   1               global enable; 0 = issue no new grants
//   req        in   N_CORES         per-core fetch request, held until gnt
//   req_addr   in   N_CORES*ADDR_W  packed addresses, core i at [i*ADDR_W +: ADDR_W]
//   gnt        out  N_CORES         one-hot grant, same cycle as mem_en
//   rvalid     out  N_CORES         one-hot: rdata belongs to core i this cycle
//   rdata      out  DATA_W          fetched instruction (broadcast to all cores)
//   mem_en     out  1               memory read enable
//   mem_addr   out  ADDR_W          memory read address
//   mem_data   in   DATA_W          memory read data, valid 1 cycle after mem_en
// BEHAVIOUR
//   - State registers:
//     - ptr: priority pointer, log2(N_CORES) bits.
//     - rvalid_q: N_CORES bits.
//   - Reset (async, immediate): ptr=0, rvalid_q=0. While rst=1, gnt=0 and mem_en=0.
//     mem_addr=0, rvalid=0, rdata=mem_data (don't-care).
//   - Arbitration (combinational, cycle t):
//     - Search req starting at index ptr, ascending, wrapping N_CORES-1 -> 0.
//     - The first set index w gets gnt[w]=1.
//     - mem_en=1, mem_addr=req_addr[w].
//     - No req, or en=0: gnt=0, mem_en=0, mem_addr=0.
//   - Pointer update (rising edge after a grant): ptr <= (w+1) mod N_CORES.
//     No grant: ptr holds.
//   - Return (cycle t+1): rvalid_q <= gnt, so rvalid[w]=1 for exactly one cycle.
//     rdata = mem_data (combinational passthrough). Latency grant->data = 1 cycle.
//   - Throughput: one grant per cycle, no bubbles.
//     - A new grant may issue in the same cycle as the previous rvalid (pipelined).
//     - A lone requester holding req high is granted every cycle.
//   - Requester rules:
//     - req_addr must stay stable while req=1 and gnt=0.
//     - Dropping req before gnt is legal and withdraws the request.
//     - req asserted in the same cycle as the grant is sampled combinationally.
//   - Fairness: a continuously requesting core waits at most N_CORES-1 cycles
//     for a grant.
//   - en falling: no new grants from that cycle on. An already-issued fetch
//     still returns its rvalid on the next cycle.
//   - rst mid-fetch: the pending rvalid is discarded (rvalid_q cleared) and
//     ptr returns to 0. The core must re-request after reset.
//   - gnt and rvalid are each always one-hot or zero. Checked by assertion.
// TESTING
//   1 reset: rst=1 with req=4'b1111 -> gnt=0, mem_en=0, rvalid=0.
//     Release rst -> first gnt=4'b0001.
//   2 single requester: req=4'b0100, addr2=5 held 3 cycles
//     -> gnt=4'b0100 and mem_addr=5 each cycle.
//     rvalid=4'b0100 on cycles t+1..t+3, rdata=progmem[5].
//   3 all request: req=4'b1111 held 6 cycles
//     -> gnt sequence 0001,0010,0100,1000,0001,0010 (wrap check).
//     rvalid follows one cycle behind.
//   4 pointer skip: after a grant to core 1, req=4'b0011
//     -> next gnt=4'b0001 (search starts at 2 and wraps to 0), then 4'b0010.
//   5 en toggle: req=4'b1111, en=0 on cycle 3 -> no gnt from cycle 3.
//     rvalid of the cycle-2 grant still appears on cycle 3. en=1 resumes at ptr.
//   6 rst mid-fetch: grant core 3, assert rst in the next half-cycle
//     -> rvalid stays 0 and ptr=0 after release.

Source files
------------

// File: rtl/progmem_arbiter.sv
`default_nettype none
// ============================================================================
// progmem_arbiter: round-robin sharing of one synchronous-read program memory
// Rev 1.0 - initial release
// ============================================================================
module progmem_arbiter #(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [N_CORES-1:0]        req,
  input  logic [N_CORES*ADDR_W-1:0] req_addr,
  output logic [N_CORES-1:0]        gnt,
  output logic [N_CORES-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_data
);

  localparam int c_PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(N_CORES - 1);

  logic [c_PTR_W-1:0] r_ptr;
  logic [N_CORES-1:0] r_rvalid;
  logic [c_PTR_W-1:0] w_win;
  logic               w_found;
  logic               w_grant;

  // Scan from the pointer upwards with wrap; the first requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N_CORES; k++) begin
      int idx;
      idx = (int'(r_ptr) + k) % N_CORES;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = c_PTR_W'(idx);
      end
    end
  end

  // Reset also gates the grant path so nothing reaches memory while held.
  assign w_grant = w_found & en & ~rst;

  always_comb begin
    gnt      = '0;
    mem_en   = 1'b0;
    mem_addr = '0;
    if (w_grant) begin
      gnt[w_win] = 1'b1;
      mem_en     = 1'b1;
      mem_addr   = req_addr[w_win*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= gnt;
      if (w_grant) begin
        r_ptr <= (w_win == c_LAST) ? '0 : w_win + 1'b1;
      end
    end
  end

  assign rvalid = r_rvalid;
  assign rdata  = mem_data;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_rvalid_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(rvalid));

endmodule
`default_nettype wire

// File: tb/tb_progmem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_progmem_arbiter: scoreboard bench with directed and random fetch traffic
// Rev 1.0 - initial release
// ============================================================================
module tb_progmem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data = '0;

  progmem_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .mem_en   (mem_en),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            core;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   m_ptr   = 0;
  int   exp_win = -1;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return {a, ~a} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Program memory: synchronous read, one cycle after mem_en
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) mem_data <= mem_f(mem_addr);
  end

  // Reference model: winner is the requester closest to the pointer going upward
  always @(negedge clk) begin
    int best, bd, d;
    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    best = -1;
    bd   = N;
    if (!rst && en) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          d = (i - m_ptr + N) % N;
          if (d < bd) begin
            bd   = d;
            best = i;
          end
        end
      end
    end
    exp_win = best;
    eg = '0;
    ea = '0;
    if (best >= 0) begin
      eg[best] = 1'b1;
      ea = req_addr[best*AW +: AW];
      q.push_back('{best, mem_f(ea), cyc + 1});
    end
    chk("gnt", 64'(gnt), 64'(eg));
    chk("mem_en", 64'(mem_en), 64'(best >= 0));
    chk("mem_addr", 64'(mem_addr), 64'(ea));
  end

  always @(posedge clk or posedge rst) begin
    if (rst) m_ptr <= 0;
    else if (exp_win >= 0) m_ptr <= (exp_win + 1) % N;
  end

  // A fetch in flight at reset is discarded
  always @(posedge rst) q.delete();

  // Monitor: pop an expectation whenever the DUT presents returned data
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rvalid_in_reset", 64'(rvalid), 64'd0);
    end else if (rvalid != '0) begin
      if (q.size() == 0) begin
        chk("rvalid_unexpected", 64'(rvalid), 64'd0);
      end else begin
        e = q.pop_front();
        chk("rvalid", 64'(rvalid), 64'(1) << e.core);
        chk("rdata", 64'(rdata), 64'(e.data));
        chk("rvalid_cycle", 64'(cyc), 64'(e.due));
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("rvalid_missing", 64'(rvalid), 64'(1) << e.core);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_addr(input int core, input logic [AW-1:0] a);
    req_addr[core*AW +: AW] = a;
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_addr(i, AW'(16'h100 + i));
    // Reset held with all cores requesting, then released
    req = 4'b1111;
    step(3);
    rst = 1'b0;
    step(2);
    req = 4'b0000;
    step(2);

    // Lone requester granted back-to-back
    set_addr(2, 16'd5);
    req = 4'b0100;
    step(3);
    req = 4'b0000;
    step(2);

    // All request from a fresh pointer: wrap check
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    req = 4'b1111;
    step(6);
    req = 4'b0000;
    step(2);

    // Pointer skip: grant core 1, then cores 0 and 1 compete
    req = 4'b0010;
    step(1);
    req = 4'b0011;
    step(2);
    req = 4'b0000;
    step(2);

    // Enable toggle
    req = 4'b1111;
    step(2);
    en = 1'b0;
    step(2);
    en = 1'b1;
    step(3);
    req = 4'b0000;
    step(2);

    // Reset while a fetch for core 3 is in flight
    req = 4'b1000;
    step(1);
    rst = 1'b1;
    req = 4'b0000;
    step(2);
    rst = 1'b0;
    req = 4'b1111;
    step(2);
    req = 4'b0000;
    step(2);

    // Random traffic with withdrawals and enable drops
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (exp_win == i) begin
            req[i] = 1'($urandom_range(0, 1));
            if (req[i]) set_addr(i, AW'($urandom));
          end else if ($urandom_range(0, 7) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 1) == 1) begin
          req[i] = 1'b1;
          set_addr(i, AW'($urandom));
        end
      end
      en = ($urandom_range(0, 9) != 0);
      step(1);
    end
    req = '0;
    en  = 1'b1;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
